// File: rtl/udma_eth_rx_frame_tracker.sv
// Eth-side RX frame tracker: measures and classifies frames on the MAC->FIFO stream,
// allocates L2 buffer slots round-robin and queues one descriptor per committed frame.
module udma_eth_rx_frame_tracker #(
  parameter int unsigned LEN_WIDTH  = 14,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 eth_clk_i,
  input  logic                 eth_rstn_i,
  input  logic                 s_axis_tvalid_i,
  input  logic                 s_axis_tready_i,
  input  logic                 s_axis_tlast_i,
  input  logic                 s_axis_tuser_i,
  input  logic                 cfg_en_i,
  input  logic                 cnt_clr_i,
  input  logic [NUM_SLOTS-1:0] slot_release_i,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic [LEN_WIDTH-1:0] desc_len_o,
  output logic [SW-1:0]        desc_slot_o,
  output logic [2:0]           desc_err_o,
  output logic [SW-1:0]        wr_slot_o,
  output logic [NUM_SLOTS-1:0] slots_busy_o,
  output logic                 in_frame_o,
  output logic                 pkt_event_o,
  output logic                 err_event_o,
  output logic                 drop_event_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned PW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int unsigned CW = $clog2(DESC_DEPTH + 1);
  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DISCARD} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   bad_q, bad_d;
  logic [SW-1:0]          wr_slot_q, wr_slot_d;
  logic [NUM_SLOTS-1:0]   busy_q, busy_d;
  logic [LEN_WIDTH-1:0]   len_mem_q [DESC_DEPTH];
  logic [LEN_WIDTH-1:0]   len_mem_d [DESC_DEPTH];
  logic [SW-1:0]          slot_mem_q [DESC_DEPTH];
  logic [SW-1:0]          slot_mem_d [DESC_DEPTH];
  logic [2:0]             err_mem_q [DESC_DEPTH];
  logic [2:0]             err_mem_d [DESC_DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                   pkt_ev_q, pkt_ev_d, err_ev_q, err_ev_d, drop_ev_q, drop_ev_d;

  logic                   beat, commit, accept, drop, pop, full;
  logic [LEN_WIDTH-1:0]   len_inc, cmt_len;
  logic                   cmt_bad;
  logic [2:0]             cmt_err;

  assign beat    = s_axis_tvalid_i & s_axis_tready_i;
  assign len_inc = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
  assign cmt_err = {cmt_len > MAX_L, cmt_len < MIN_L, cmt_bad};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DESC_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                    input logic clr, input logic inc);
    if (clr)           return '0;
    if (inc && !(&c))  return c + CNT_WIDTH'(1);
    return c;
  endfunction

  // Frame FSM: length/bad accumulation and commit request on the tlast beat
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bad_d   = bad_q;
    commit  = 1'b0;
    cmt_len = len_inc;
    cmt_bad = bad_q | s_axis_tuser_i;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          if (cfg_en_i) begin
            if (s_axis_tlast_i) begin
              commit  = 1'b1;
              cmt_len = LEN_WIDTH'(1);
              cmt_bad = s_axis_tuser_i;
            end else begin
              state_d = S_TRACK;
              len_d   = LEN_WIDTH'(1);
              bad_d   = s_axis_tuser_i;
            end
          end else if (!s_axis_tlast_i) begin
            state_d = S_DISCARD;
          end
        end
      end
      S_TRACK: begin
        if (beat) begin
          if (s_axis_tlast_i) begin
            commit  = 1'b1;
            state_d = S_IDLE;
            len_d   = '0;
            bad_d   = 1'b0;
          end else begin
            len_d = len_inc;
            bad_d = cmt_bad;
          end
        end
      end
      S_DISCARD: begin
        if (beat && s_axis_tlast_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit arbitration uses registered full/busy, so a same-cycle pop or release cannot rescue it
  always_comb begin
    full       = (count_q == CW'(DESC_DEPTH));
    accept     = commit & ~full & ~busy_q[wr_slot_q];
    drop       = commit & ~accept;
    pop        = valid_q & desc_ready_i;
    len_mem_d  = len_mem_q;
    slot_mem_d = slot_mem_q;
    err_mem_d  = err_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    busy_d     = busy_q & ~slot_release_i;
    wr_slot_d  = wr_slot_q;
    if (accept) begin
      len_mem_d[wptr_q]  = cmt_len;
      slot_mem_d[wptr_q] = wr_slot_q;
      err_mem_d[wptr_q]  = cmt_err;
      wptr_d             = ptr_inc(wptr_q);
      busy_d[wr_slot_q]  = 1'b1;
      wr_slot_d          = (wr_slot_q == SW'(NUM_SLOTS - 1)) ? '0 : wr_slot_q + SW'(1);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    valid_d    = (count_d != '0);
    pkt_ev_d   = accept;
    err_ev_d   = accept & (cmt_err != 3'b000);
    drop_ev_d  = drop;
    pkt_cnt_d  = cnt_next(pkt_cnt_q, cnt_clr_i, pkt_ev_d);
    err_cnt_d  = cnt_next(err_cnt_q, cnt_clr_i, err_ev_d);
    drop_cnt_d = cnt_next(drop_cnt_q, cnt_clr_i, drop_ev_d);
  end

  always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
    if (!eth_rstn_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      bad_q      <= 1'b0;
      wr_slot_q  <= '0;
      busy_q     <= '0;
      len_mem_q  <= '{default: '0};
      slot_mem_q <= '{default: '0};
      err_mem_q  <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pkt_ev_q   <= 1'b0;
      err_ev_q   <= 1'b0;
      drop_ev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      wr_slot_q  <= wr_slot_d;
      busy_q     <= busy_d;
      len_mem_q  <= len_mem_d;
      slot_mem_q <= slot_mem_d;
      err_mem_q  <= err_mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pkt_ev_q   <= pkt_ev_d;
      err_ev_q   <= err_ev_d;
      drop_ev_q  <= drop_ev_d;
    end
  end

  assign desc_valid_o = valid_q;
  assign desc_len_o   = len_mem_q[rptr_q];
  assign desc_slot_o  = slot_mem_q[rptr_q];
  assign desc_err_o   = err_mem_q[rptr_q];
  assign wr_slot_o    = wr_slot_q;
  assign slots_busy_o = busy_q;
  assign in_frame_o   = (state_q == S_TRACK);
  assign pkt_event_o  = pkt_ev_q;
  assign err_event_o  = err_ev_q;
  assign drop_event_o = drop_ev_q;
  assign pkt_cnt_o    = pkt_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
